// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: shared UART receiver state encoding and bit-timer load derivation
package uart_rx_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
  localparam int CLKS_PER_BIT_DEF = 217;
  function automatic logic [7:0] half_load(input int cpb);
    return 8'(cpb / 2 - 1);
  endfunction
  function automatic logic [7:0] full_load(input int cpb);
    return 8'(cpb - 1);
  endfunction
endpackage

// File: rtl/rx_sync2.sv
// rx_sync2: two-flop synchronizer for an idle-high asynchronous line
module rx_sync2 (
  input  logic CLOCK,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge CLOCK or negedge reset_n)
    if (!reset_n) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving an external bit-timing down-counter
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       CLOCK,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       rx,
  input  logic       tmr_co,
  output logic       tmr_load,
  output logic [7:0] tmr_load_value,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [7:0] HALF_LOAD = half_load(CLKS_PER_BIT);
  localparam logic [7:0] FULL_LOAD = full_load(CLKS_PER_BIT);
  rx_state_t state, state_nxt;
  logic rx_s, rx_prev, start_edge;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [7:0] shreg, shreg_nxt, load_val_nxt;
  logic load_nxt, valid_nxt, err_nxt;
  rx_sync2 u_sync (.CLOCK(CLOCK), .reset_n(reset_n), .d(rx), .q(rx_s));
  assign start_edge = rx_prev & ~rx_s;
  always_ff @(posedge CLOCK or negedge reset_n)
    if (!reset_n) begin
      state          <= IDLE;
      rx_prev        <= 1'b1;
      bit_idx        <= 3'd0;
      shreg          <= 8'h00;
      tmr_load       <= 1'b0;
      tmr_load_value <= 8'h00;
      rx_data        <= 8'h00;
      rx_valid       <= 1'b0;
      frame_err      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      rx_prev        <= rx_s;
      bit_idx        <= bit_idx_nxt;
      shreg          <= shreg_nxt;
      tmr_load       <= load_nxt;
      tmr_load_value <= load_val_nxt;
      rx_data        <= valid_nxt ? shreg : rx_data;
      rx_valid       <= valid_nxt;
      frame_err      <= err_nxt;
      busy           <= state_nxt != IDLE;
    end
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    if (!rx_en) state_nxt = IDLE;
    else
      case (state)
        IDLE:  state_nxt = start_edge ? START : IDLE;
        START: if (tmr_co) begin
          state_nxt   = rx_s ? IDLE : DATA;
          bit_idx_nxt = 3'd0;
        end
        DATA:  if (tmr_co) begin
          shreg_nxt[bit_idx] = rx_s;
          bit_idx_nxt        = bit_idx + 3'd1;
          state_nxt          = bit_idx == 3'd7 ? STOP : DATA;
        end
        STOP:  state_nxt = tmr_co ? IDLE : STOP;
      endcase
  end
  always_comb begin
    load_nxt     = 1'b0;
    load_val_nxt = 8'h00;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;
    if (rx_en)
      case (state)
        IDLE:  if (start_edge) begin
          load_nxt     = 1'b1;
          load_val_nxt = HALF_LOAD;
        end
        START: if (tmr_co && !rx_s) begin
          load_nxt     = 1'b1;
          load_val_nxt = FULL_LOAD;
        end
        DATA:  if (tmr_co) begin
          load_nxt     = 1'b1;
          load_val_nxt = FULL_LOAD;
        end
        STOP:  if (tmr_co) begin
          valid_nxt = rx_s;
          err_nxt   = ~rx_s;
        end
      endcase
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench with a counter model and frame-level reference
module tb_uart_rx_ctrl;
  localparam int CPB = 16;
  localparam logic [7:0] HALF = 8'd7;
  localparam logic [7:0] FULL = 8'd15;
  typedef struct {bit err; logic [7:0] data;} ev_t;
  logic CLOCK = 1'b0, reset_n = 1'b0, rx_en = 1'b0, rx = 1'b1;
  logic tmr_co, tmr_load, rx_valid, frame_err, busy;
  logic [7:0] tmr_load_value, rx_data;
  int checks = 0, passed = 0, loads = 0;
  ev_t expq[$];
  logic [7:0] last_good = 8'h00;
  logic [8:0] cnt;
  logic armed;
  logic prev_strobe = 1'b0, prev_load = 1'b0, prev_busy = 1'b0;
  always #5 CLOCK = ~CLOCK;
  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .rx_en(rx_en), .rx(rx), .tmr_co(tmr_co),
    .tmr_load(tmr_load), .tmr_load_value(tmr_load_value), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );
  always @(posedge CLOCK or negedge reset_n)
    if (!reset_n) begin
      cnt <= 9'd0;
      armed <= 1'b0;
    end else if (tmr_load) begin
      cnt <= {1'b0, tmr_load_value};
      armed <= 1'b1;
    end else if (armed) begin
      cnt <= cnt - 9'd1;
      if (cnt == 9'd1) armed <= 1'b0;
    end
  assign tmr_co = armed && cnt == 9'd1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge CLOCK) begin
    if (reset_n && (rx_valid || frame_err)) begin
      chk("strobe_width", {31'd0, prev_strobe}, 0);
      if (expq.size() == 0) chk("unexpected_strobe", {rx_valid, frame_err}, 0);
      else begin
        ev_t e;
        e = expq.pop_front();
        chk("strobe_kind", {rx_valid, frame_err}, e.err ? 2'b01 : 2'b10);
        chk("rx_data", rx_data, e.data);
        chk("busy_at_strobe", busy, 0);
      end
    end
    prev_strobe = reset_n && (rx_valid || frame_err);
  end
  always @(negedge CLOCK) begin
    if (reset_n && tmr_load) begin
      loads++;
      chk("load_value", tmr_load_value, prev_busy ? FULL : HALF);
      chk("load_back2back", prev_load, 0);
    end
    prev_load = reset_n && tmr_load;
    prev_busy = reset_n && busy;
  end
  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge CLOCK);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop);
    ev_t e;
    e.err = !stop;
    e.data = stop ? b : last_good;
    if (stop) last_good = b;
    expq.push_back(e);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    line(stop, CPB);
  endtask
  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 4000) begin
      @(negedge CLOCK);
      n++;
    end
    chk("drain", expq.size(), 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int l0;
    logic [7:0] p, b;
    bit stop;
    repeat (3) @(negedge CLOCK);
    chk("rst_load", tmr_load, 0);
    chk("rst_load_value", tmr_load_value, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_strobes", {rx_valid, frame_err}, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    rx_en = 1'b1;
    line(1'b1, 20);
    l0 = loads;
    send_frame(8'hA5, 1'b1);
    line(1'b1, 20);
    drain();
    chk("a5_loads", loads - l0, 10);
    l0 = loads;
    line(1'b0, 3);
    line(1'b1, 40);
    chk("glitch_loads", loads - l0, 1);
    chk("glitch_busy", busy, 0);
    l0 = loads;
    send_frame(8'h3C, 1'b0);
    line(1'b0, 64);
    chk("ferr_loads", loads - l0, 10);
    chk("ferr_busy", busy, 0);
    chk("ferr_data_kept", rx_data, 8'hA5);
    line(1'b1, 20);
    drain();
    l0 = loads;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    line(1'b1, 20);
    drain();
    chk("b2b_loads", loads - l0, 20);
    p = 8'h55;
    line(1'b0, CPB);
    for (int i = 0; i < 4; i++) line(p[i], CPB);
    line(p[4], 5);
    chk("mid_frame_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_data", rx_data, 0);
    chk("async_rst_load", {tmr_load, tmr_load_value}, 0);
    chk("async_rst_strobes", {rx_valid, frame_err}, 0);
    last_good = 8'h00;
    line(1'b1, 3);
    reset_n = 1'b1;
    line(1'b1, 20);
    chk("post_rst_idle", busy, 0);
    send_frame(8'h81, 1'b1);
    line(1'b1, 20);
    drain();
    line(1'b0, CPB);
    line(1'b1, CPB);
    line(1'b0, 5);
    rx_en = 1'b0;
    line(1'b0, 2);
    chk("abort_busy", busy, 0);
    line(1'b1, CPB * 8);
    chk("abort_no_load", tmr_load, 0);
    rx_en = 1'b1;
    line(1'b1, 20);
    send_frame(8'h7E, 1'b1);
    line(1'b1, 20);
    drain();
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      send_frame(b, stop);
      if (!stop) line(1'b0, $urandom_range(0, 30));
      line(1'b1, stop ? $urandom_range(0, 20) : $urandom_range(2, 20));
    end
    line(1'b1, 20);
    drain();
    chk("final_busy", busy, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
